// File: rtl/partition_fill.sv
`default_nettype none
// partition_fill: streaming quickselect partition stage; splits a pass into lower/equal/larger
// buffers and tracks their sizes and extrema. Revision 1.0
module partition_fill #(
  parameter int BUFF_SIZE     = 32,
  parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [7:0]               in_pivot,
  input  logic [BUFF_SIZE_BIT-1:0] in_buff_size,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic [1:0]               wr_sel,
  output logic [BUFF_SIZE_BIT-1:0] wr_addr,
  output logic [7:0]               wr_data,
  output logic [BUFF_SIZE_BIT-1:0] lower_size,
  output logic [BUFF_SIZE_BIT-1:0] equal_size,
  output logic [BUFF_SIZE_BIT-1:0] larger_size,
  output logic [7:0]               max_lower,
  output logic [7:0]               min_lower,
  output logic [7:0]               max_larger,
  output logic [7:0]               min_larger,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [BUFF_SIZE_BIT-1:0] MAX_COUNT = BUFF_SIZE_BIT'(BUFF_SIZE);
  localparam logic [BUFF_SIZE_BIT-1:0] ONE       = BUFF_SIZE_BIT'(1);
  localparam logic [1:0]               SEL_LOWER  = 2'b00;
  localparam logic [1:0]               SEL_EQUAL  = 2'b01;
  localparam logic [1:0]               SEL_LARGER = 2'b10;

  state_t                     state_q, state_d;
  logic [7:0]                 pivot_q, pivot_d;
  logic [BUFF_SIZE_BIT-1:0]   count_q, count_d;
  logic [BUFF_SIZE_BIT-1:0]   elem_cnt_q, elem_cnt_d;
  logic [BUFF_SIZE_BIT-1:0]   lower_size_q, lower_size_d;
  logic [BUFF_SIZE_BIT-1:0]   equal_size_q, equal_size_d;
  logic [BUFF_SIZE_BIT-1:0]   larger_size_q, larger_size_d;
  logic [7:0]                 max_lower_q, max_lower_d;
  logic [7:0]                 min_lower_q, min_lower_d;
  logic [7:0]                 max_larger_q, max_larger_d;
  logic [7:0]                 min_larger_q, min_larger_d;
  logic                       wr_en_q, wr_en_d;
  logic [1:0]                 wr_sel_q, wr_sel_d;
  logic [BUFF_SIZE_BIT-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]                 wr_data_q, wr_data_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  always_comb begin
    state_d       = state_q;
    pivot_d       = pivot_q;
    count_d       = count_q;
    elem_cnt_d    = elem_cnt_q;
    lower_size_d  = lower_size_q;
    equal_size_d  = equal_size_q;
    larger_size_d = larger_size_q;
    max_lower_d   = max_lower_q;
    min_lower_d   = min_lower_q;
    max_larger_d  = max_larger_q;
    min_larger_d  = min_larger_q;
    wr_en_d       = 1'b0;
    wr_sel_d      = wr_sel_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          pivot_d       = in_pivot;
          count_d       = (in_buff_size > MAX_COUNT) ? MAX_COUNT : in_buff_size;
          elem_cnt_d    = '0;
          lower_size_d  = '0;
          equal_size_d  = '0;
          larger_size_d = '0;
          max_lower_d   = 8'h00;
          min_lower_d   = 8'hFF;
          max_larger_d  = 8'h00;
          min_larger_d  = 8'hFF;
          // An empty pass spends an extra cycle in DONE before raising done.
          state_d       = (count_d == '0) ? DONE : FILL;
        end
      end

      FILL: begin
        if (in_valid) begin
          wr_en_d    = 1'b1;
          wr_data_d  = in_data;
          elem_cnt_d = elem_cnt_q + ONE;
          if (in_data < pivot_q) begin
            wr_sel_d     = SEL_LOWER;
            wr_addr_d    = lower_size_q;
            lower_size_d = lower_size_q + ONE;
            if (in_data > max_lower_q) max_lower_d = in_data;
            if (in_data < min_lower_q) min_lower_d = in_data;
          end else if (in_data == pivot_q) begin
            wr_sel_d     = SEL_EQUAL;
            wr_addr_d    = equal_size_q;
            equal_size_d = equal_size_q + ONE;
          end else begin
            wr_sel_d      = SEL_LARGER;
            wr_addr_d     = larger_size_q;
            larger_size_d = larger_size_q + ONE;
            if (in_data > max_larger_q) max_larger_d = in_data;
            if (in_data < min_larger_q) min_larger_d = in_data;
          end
          if (elem_cnt_d == count_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      DONE: begin
        if (done_q) begin
          state_d = IDLE;
        end else begin
          done_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pivot_q       <= 8'h00;
      count_q       <= '0;
      elem_cnt_q    <= '0;
      lower_size_q  <= '0;
      equal_size_q  <= '0;
      larger_size_q <= '0;
      max_lower_q   <= 8'h00;
      min_lower_q   <= 8'hFF;
      max_larger_q  <= 8'h00;
      min_larger_q  <= 8'hFF;
      wr_en_q       <= 1'b0;
      wr_sel_q      <= 2'b00;
      wr_addr_q     <= '0;
      wr_data_q     <= 8'h00;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pivot_q       <= pivot_d;
      count_q       <= count_d;
      elem_cnt_q    <= elem_cnt_d;
      lower_size_q  <= lower_size_d;
      equal_size_q  <= equal_size_d;
      larger_size_q <= larger_size_d;
      max_lower_q   <= max_lower_d;
      min_lower_q   <= min_lower_d;
      max_larger_q  <= max_larger_d;
      min_larger_q  <= min_larger_d;
      wr_en_q       <= wr_en_d;
      wr_sel_q      <= wr_sel_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign in_ready    = (state_q == FILL);
  assign wr_en       = wr_en_q;
  assign wr_sel      = wr_sel_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign lower_size  = lower_size_q;
  assign equal_size  = equal_size_q;
  assign larger_size = larger_size_q;
  assign max_lower   = max_lower_q;
  assign min_lower   = min_lower_q;
  assign max_larger  = max_larger_q;
  assign min_larger  = min_larger_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_partition_fill.sv
`default_nettype none
// tb_partition_fill: directed and randomized passes checked against a queue-level partition model.
module tb_partition_fill;
  localparam int BS  = 32;
  localparam int BSB = $clog2(BS) + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [7:0]     in_pivot = 8'h00;
  logic [BSB-1:0] in_buff_size = '0;
  logic [7:0]     in_data = 8'h00;
  logic           in_valid = 1'b0;
  logic           in_ready, wr_en, busy, done;
  logic [1:0]     wr_sel;
  logic [BSB-1:0] wr_addr, lower_size, equal_size, larger_size;
  logic [7:0]     wr_data, max_lower, min_lower, max_larger, min_larger;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] dat [0:63];

  partition_fill #(.BUFF_SIZE(BS), .BUFF_SIZE_BIT(BSB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_pivot(in_pivot),
    .in_buff_size(in_buff_size), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .lower_size(lower_size), .equal_size(equal_size),
    .larger_size(larger_size), .max_lower(max_lower), .min_lower(min_lower),
    .max_larger(max_larger), .min_larger(min_larger), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 = lower, 1 = equal, 2 = larger; also the wr_sel code.
  function automatic int cls(input logic [7:0] v, input logic [7:0] p);
    if (v < p) return 0;
    if (v == p) return 1;
    return 2;
  endfunction

  function automatic int cnt_cls(input int c, input int n, input logic [7:0] p);
    int k = 0;
    for (int i = 0; i < n; i++) if (cls(dat[i], p) == c) k++;
    return k;
  endfunction

  function automatic logic [7:0] ext(input int c, input int n, input logic [7:0] p, input bit want_max);
    logic [7:0] r;
    r = want_max ? 8'h00 : 8'hFF;
    for (int i = 0; i < n; i++) begin
      if (cls(dat[i], p) == c) begin
        if (want_max && dat[i] > r) r = dat[i];
        if (!want_max && dat[i] < r) r = dat[i];
      end
    end
    return r;
  endfunction

  task automatic check_results(input string tag, input logic [7:0] p, input int n);
    chk({tag, ".lower_size"},  32'(lower_size),  32'(cnt_cls(0, n, p)));
    chk({tag, ".equal_size"},  32'(equal_size),  32'(cnt_cls(1, n, p)));
    chk({tag, ".larger_size"}, 32'(larger_size), 32'(cnt_cls(2, n, p)));
    chk({tag, ".max_lower"},   32'(max_lower),   32'(ext(0, n, p, 1'b1)));
    chk({tag, ".min_lower"},   32'(min_lower),   32'(ext(0, n, p, 1'b0)));
    chk({tag, ".max_larger"},  32'(max_larger),  32'(ext(2, n, p, 1'b1)));
    chk({tag, ".min_larger"},  32'(min_larger),  32'(ext(2, n, p, 1'b0)));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".wr_en"}, 32'(wr_en), 0);
    chk({tag, ".wr_sel"}, 32'(wr_sel), 0);
    chk({tag, ".wr_addr"}, 32'(wr_addr), 0);
    chk({tag, ".wr_data"}, 32'(wr_data), 0);
    chk({tag, ".sizes"}, {lower_size, equal_size, larger_size}, 0);
    chk({tag, ".max"}, {max_lower, max_larger}, 32'h0000);
    chk({tag, ".min"}, {min_lower, min_larger}, 32'hFFFF);
  endtask

  task automatic run_pass(input string tag, input logic [7:0] p, input int req,
                          input int bubble_pct, input int stall_at, input int stall_len,
                          input bit poke_start);
    int n;
    int idx;
    int budget;
    int stalled;
    bit v;
    n = (req > BS) ? BS : req;
    idx = 0;
    budget = 0;
    stalled = 0;
    in_pivot = p;
    in_buff_size = BSB'(req);
    start = 1'b1;
    step();
    start = 1'b0;
    in_pivot = 8'($urandom);
    in_buff_size = BSB'($urandom);
    if (n == 0) begin
      chk({tag, ".empty.done0"}, 32'(done), 0);
      chk({tag, ".empty.busy"}, 32'(busy), 0);
      chk({tag, ".empty.in_ready"}, 32'(in_ready), 0);
      step();
      chk({tag, ".empty.done1"}, 32'(done), 1);
      check_results({tag, ".empty"}, p, 0);
      step();
      chk({tag, ".empty.done_pulse"}, 32'(done), 0);
      return;
    end
    chk({tag, ".busy_start"}, 32'(busy), 1);
    check_results({tag, ".cleared"}, p, 0);
    while (idx < n && budget < 1000) begin
      chk({tag, ".in_ready"}, 32'(in_ready), 1);
      if (idx == stall_at && stalled < stall_len) begin
        v = 1'b0;
        stalled++;
      end else begin
        v = ($urandom_range(99) >= bubble_pct);
      end
      in_valid = v;
      in_data = v ? dat[idx] : 8'($urandom);
      if (poke_start && idx == 2) begin
        start = 1'b1;
        in_buff_size = BSB'(1);
      end
      step();
      start = 1'b0;
      in_valid = 1'b0;
      budget++;
      if (v) begin
        chk({tag, ".wr_en"}, 32'(wr_en), 1);
        chk({tag, ".wr_sel"}, 32'(wr_sel), 32'(cls(dat[idx], p)));
        chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(cnt_cls(cls(dat[idx], p), idx, p)));
        chk({tag, ".wr_data"}, 32'(wr_data), 32'(dat[idx]));
        idx++;
        if (idx == n) begin
          chk({tag, ".done"}, 32'(done), 1);
          chk({tag, ".busy_end"}, 32'(busy), 0);
          chk({tag, ".ready_end"}, 32'(in_ready), 0);
          check_results({tag, ".final"}, p, n);
        end else begin
          chk({tag, ".done_early"}, 32'(done), 0);
          chk({tag, ".partial_sizes"}, {lower_size, equal_size, larger_size},
              {BSB'(cnt_cls(0, idx, p)), BSB'(cnt_cls(1, idx, p)), BSB'(cnt_cls(2, idx, p))});
        end
      end else begin
        chk({tag, ".bubble_wr_en"}, 32'(wr_en), 0);
        chk({tag, ".bubble_done"}, 32'(done), 0);
        chk({tag, ".bubble_busy"}, 32'(busy), 1);
      end
    end
    chk({tag, ".pass_complete"}, 32'(idx), 32'(n));
    // Stray valid after done must be ignored and results must hold.
    in_valid = 1'b1;
    in_data = 8'($urandom);
    step();
    in_valid = 1'b0;
    chk({tag, ".post_done"}, 32'(done), 0);
    chk({tag, ".post_wr_en"}, 32'(wr_en), 0);
    chk({tag, ".post_busy"}, 32'(busy), 0);
    check_results({tag, ".hold"}, p, n);
  endtask

  initial begin
    logic [7:0] p;
    int sz;
    rst_n = 1'b0;
    step();
    step();
    check_reset_vals("reset");
    rst_n = 1'b1;
    step();

    // Reset mid-pass after 3 of 8 elements.
    for (int i = 0; i < 8; i++) dat[i] = 8'($urandom);
    in_pivot = 8'd100;
    in_buff_size = BSB'(8);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = dat[i];
      step();
    end
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    step();
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    check_reset_vals("after_reset");
    for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
    run_pass("restart4", 8'($urandom), 4, 0, -1, 0, 1'b0);

    // Mixed pass.
    dat[0] = 8'd50;  dat[1] = 8'd100; dat[2] = 8'd200; dat[3] = 8'd10;
    dat[4] = 8'd100; dat[5] = 8'd150; dat[6] = 8'd99;  dat[7] = 8'd255;
    run_pass("mixed", 8'd100, 8, 0, -1, 0, 1'b0);

    // All-equal full buffer.
    for (int i = 0; i < 32; i++) dat[i] = 8'd7;
    run_pass("all_equal", 8'd7, 32, 0, -1, 0, 1'b0);

    // Stall of 5 cycles between elements 2 and 3.
    dat[0] = 8'd1; dat[1] = 8'd2; dat[2] = 8'd3; dat[3] = 8'd4;
    run_pass("stall", 8'd3, 4, 0, 2, 5, 1'b0);

    run_pass("zero", 8'($urandom), 0, 0, -1, 0, 1'b0);

    for (int i = 0; i < 40; i++) dat[i] = 8'($urandom);
    run_pass("clamp40", 8'($urandom), 40, 20, -1, 0, 1'b0);

    for (int i = 0; i < 10; i++) dat[i] = 8'($urandom);
    run_pass("start_in_fill", 8'($urandom), 10, 0, -1, 0, 1'b1);

    // Randomized passes with values clustered around the pivot and extreme values.
    for (int t = 0; t < 8; t++) begin
      p = 8'($urandom);
      sz = $urandom_range(1, 32);
      for (int i = 0; i < sz; i++) begin
        case ($urandom_range(3))
          0: dat[i] = p;
          1: dat[i] = p + 8'($urandom_range(2)) - 8'd1;
          2: dat[i] = ($urandom_range(1) == 0) ? 8'h00 : 8'hFF;
          default: dat[i] = 8'($urandom);
        endcase
      end
      run_pass("random", p, sz, 30, $urandom_range(0, 31), $urandom_range(0, 4), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
